// File: rtl/fifo_sync_flags_if.sv
// Handshake/status bundle for fifo_sync_flags.
// The master side (producer/consumer) drives requests; the slave side (FIFO) drives data and flags.
interface fifo_sync_flags_if #(
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 1024
);
   localparam int LEVEL_W = $clog2(DEPTH + 1);

   logic                  flush;
   logic                  wr_en;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  rd_en;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  rd_valid;
   logic                  empty;
   logic                  full;
   logic                  almost_empty;
   logic                  almost_full;
   logic [LEVEL_W-1:0]    level;
   logic                  overflow;
   logic                  underflow;

   modport master (
      output flush, wr_en, wr_data, rd_en,
      input  rd_data, rd_valid, empty, full, almost_empty, almost_full, level, overflow, underflow
   );

   modport slave (
      input  flush, wr_en, wr_data, rd_en,
      output rd_data, rd_valid, empty, full, almost_empty, almost_full, level, overflow, underflow
   );
endinterface

// File: rtl/fifo_sync_flags.sv
// Single-clock FIFO with arbitrary depth, level/threshold flags, sticky error flags and flush.
// Define FIFO_FWFT_EN for first-word-fall-through reads; otherwise reads have one cycle of latency.
module fifo_sync_flags #(
   parameter int DATA_WIDTH    = 16,
   parameter int DEPTH         = 1024,
   parameter int AFULL_THRESH  = 1000,
   parameter int AEMPTY_THRESH = 16
) (
   input  logic             clk,
   input  logic             rst,
   fifo_sync_flags_if.slave bus
);
   localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int LEVEL_W = $clog2(DEPTH + 1);
   localparam logic [PTR_W-1:0]   PTR_LAST   = PTR_W'(DEPTH - 1);
   localparam logic [LEVEL_W-1:0] LEVEL_FULL = LEVEL_W'(DEPTH);
   localparam logic [LEVEL_W-1:0] AFULL_LVL  = LEVEL_W'(AFULL_THRESH);
   localparam logic [LEVEL_W-1:0] AEMPTY_LVL = LEVEL_W'(AEMPTY_THRESH);

   // Depth need not be a power of two, so the wrap is an explicit compare.
   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
      if (ptr == PTR_LAST) begin
         return {PTR_W{1'b0}};
      end else begin
         return ptr + PTR_W'(1);
      end
   endfunction

   logic [DATA_WIDTH-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0]      wr_ptr_r;
   logic [PTR_W-1:0]      rd_ptr_r;
   logic [LEVEL_W-1:0]    level_r;
   logic                  overflow_r;
   logic                  underflow_r;
   logic                  empty_s;
   logic                  full_s;
   logic                  rd_fire_s;
   logic                  wr_fire_s;
   logic                  wr_drop_s;
   logic                  rd_reject_s;

   // Handshake decode; flush masks both requests so no flag can be set alongside it.
   always_comb begin
      empty_s     = (level_r == {LEVEL_W{1'b0}});
      full_s      = (level_r == LEVEL_FULL);
      rd_fire_s   = bus.rd_en & ~empty_s & ~bus.flush;
      wr_fire_s   = bus.wr_en & (~full_s | rd_fire_s) & ~bus.flush;
      wr_drop_s   = bus.wr_en & ~wr_fire_s & ~bus.flush;
      rd_reject_s = bus.rd_en & empty_s & ~bus.flush;
   end

   // Storage array, intentionally not reset.
   always_ff @(posedge clk) begin
      if (wr_fire_s) begin
         mem_r[wr_ptr_r] <= bus.wr_data;
      end
   end

   // Pointers, occupancy and sticky error flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r    <= {PTR_W{1'b0}};
         rd_ptr_r    <= {PTR_W{1'b0}};
         level_r     <= {LEVEL_W{1'b0}};
         overflow_r  <= 1'b0;
         underflow_r <= 1'b0;
      end else if (bus.flush) begin
         wr_ptr_r    <= {PTR_W{1'b0}};
         rd_ptr_r    <= {PTR_W{1'b0}};
         level_r     <= {LEVEL_W{1'b0}};
         overflow_r  <= 1'b0;
         underflow_r <= 1'b0;
      end else begin
         if (wr_fire_s) begin
            wr_ptr_r <= ptr_next(wr_ptr_r);
         end
         if (rd_fire_s) begin
            rd_ptr_r <= ptr_next(rd_ptr_r);
         end
         case ({wr_fire_s, rd_fire_s})
            2'b10:   level_r <= level_r + LEVEL_W'(1);
            2'b01:   level_r <= level_r - LEVEL_W'(1);
            default: level_r <= level_r;
         endcase
         if (wr_drop_s) begin
            overflow_r <= 1'b1;
         end
         if (rd_reject_s) begin
            underflow_r <= 1'b1;
         end
      end
   end

`ifdef FIFO_FWFT_EN
   logic [DATA_WIDTH-1:0] rd_data_s;

   // Head word falls through; forced to zero while empty so reset shows a clean bus.
   always_comb begin
      rd_data_s = {DATA_WIDTH{1'b0}};
      if (empty_s) begin
         rd_data_s = {DATA_WIDTH{1'b0}};
      end else begin
         rd_data_s = mem_r[rd_ptr_r];
      end
   end

   assign bus.rd_data  = rd_data_s;
   assign bus.rd_valid = ~empty_s;
`else
   logic [DATA_WIDTH-1:0] rd_data_r;
   logic                  rd_valid_r;

   // Registered read port; rd_data holds across idle cycles and flush.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_data_r  <= {DATA_WIDTH{1'b0}};
         rd_valid_r <= 1'b0;
      end else if (bus.flush) begin
         rd_valid_r <= 1'b0;
      end else begin
         rd_valid_r <= rd_fire_s;
         if (rd_fire_s) begin
            rd_data_r <= mem_r[rd_ptr_r];
         end
      end
   end

   assign bus.rd_data  = rd_data_r;
   assign bus.rd_valid = rd_valid_r;
`endif

   assign bus.empty        = empty_s;
   assign bus.full         = full_s;
   assign bus.almost_empty = (level_r <= AEMPTY_LVL);
   assign bus.almost_full  = (level_r >= AFULL_LVL);
   assign bus.level        = level_r;
   assign bus.overflow     = overflow_r;
   assign bus.underflow    = underflow_r;
endmodule
